// File: rtl/div_iter_pkg.sv
// Shared encodings for the iterative divider: FSM states, handshake levels
// and the zero word used for cleared results.
package div_iter_pkg;

    // Controller states, 2-bit encoded
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and produces one quotient bit. Purely combinational.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtract of the divisor from the shifted-in partial remainder;
    // the top bit of the result is the borrow.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        rem_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle iterative divider for DIV/DIVU. Produces {remainder, quotient}
// one quotient bit per cycle using restoring division on operand magnitudes,
// then fixes the signs.
//
// Handshake: start_i is held high by the controller for the whole operation
// and the operands must stay stable while it is high. ready_o rises with a
// valid result_o and both are held while start_i stays high; dropping start_i
// in DivEnd releases the unit (ready_o and result_o clear on that edge).
// annul_i cancels an operation only while iterating.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic [1:0]         state_o
);

    localparam logic [5:0] LastCnt = 6'(WIDTH);

    div_state_t       state;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign state_o = state;

    // Operand magnitudes: signed mode negates a negative operand
    always_comb begin
        dividend_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        divisor_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Controller FSM with registered result and ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == ZeroWord) begin
                            state <= DivByZero;
                        end else begin
                            state   <= DivOn;
                            cnt     <= '0;
                            rem     <= '0;
                            quo     <= dividend_mag;
                            dvs     <= divisor_mag;
                            // Sign flags captured here so the fix-up does not
                            // depend on the operands after iteration starts.
                            neg_quo <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem <= signed_div_i & opdata1_i[WIDTH-1];
                        end
                    end
                end
                DivByZero: begin
                    rem   <= '0;
                    quo   <= '0;
                    state <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else if (cnt != LastCnt) begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 6'd1;
                    end else begin
                        // Quotient sign follows the operand signs; the
                        // remainder takes the dividend's sign.
                        if (neg_quo) quo <= -quo;
                        if (neg_rem) rem <= -rem;
                        state <= DivEnd;
                        cnt   <= '0;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else begin
                        ready_o  <= DivResultReady;
                        result_o <= {rem, quo};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed cases, annul and mid-operation reset, then
// randomized operations checked against an arithmetic reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic [1:0]  state_o;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .state_o      (state_o)
    );

    // Clock
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic        ready_prev = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; signed truncates toward zero and the
    // remainder carries the dividend's sign. Divide by zero yields all zeros.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            uq = a / b;
            ur = a % b;
            return {ur, uq};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Monitor: on each rising ready_o, pop the oldest expectation and compare
    always @(negedge clk) begin
        if (ready_o === 1'b1 && ready_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got result %h, expected no ready", result_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check64("monitor_result", result_o, mon_exp);
            end
        end
        ready_prev = ready_o;
    end

    // Drive a new request at a falling edge
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        if (push) exp_q.push_back(ref_div(sgn, a, b));
    endtask

    // Wait for ready, check latency, hold, then release and check clearing
    task automatic wait_done(input int exp_lat, input logic [63:0] exp_res);
        int edges = 0;
        bit seen  = 0;
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ready_o === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready after %0d edges, expected ready after %0d", edges, exp_lat);
        end else begin
            check_int("latency", edges - 1, exp_lat);
            repeat (2) @(negedge clk);
            check_int("ready_held", int'(ready_o), 1);
            check64("result_held", result_o, exp_res);
        end
        start_i = 1'b0;
        @(negedge clk);
        check_int("release_ready", int'(ready_o), 0);
        check64("release_result", result_o, 64'd0);
        check_int("release_state", int'(state_o), 0);
    endtask

    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_res);
        issue(sgn, a, b, 1);
        wait_done((b == 32'd0) ? 2 : 34, exp_res);
    endtask

    logic        r_sgn;
    logic [31:0] r_a, r_b;

    initial begin
        // Reset
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(negedge clk);
        check_int("reset_ready", int'(ready_o), 0);
        check64("reset_result", result_o, 64'd0);
        check_int("reset_state", int'(state_o), 0);
        rst = 1'b0;

        // Directed cases
        run(1'b0, 32'd100,       32'd7,         64'h00000002_0000000E);
        run(1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD);
        run(1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD);
        run(1'b1, 32'd1234,      32'd0,         64'h00000000_00000000);
        run(1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF);
        run(1'b1, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF);
        run(1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000);
        run(1'b0, 32'd0,         32'd5,         64'h00000000_00000000);

        // Annul on the 10th DivOn cycle, then an immediate new request
        issue(1'b0, 32'hDEADBEEF, 32'h00001234, 0);
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        check_int("annul_state", int'(state_o), 0);
        check_int("annul_ready", int'(ready_o), 0);
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        exp_q.push_back(ref_div(1'b0, 32'd9, 32'd3));
        wait_done(34, 64'h00000000_00000003);

        // Reset during iteration 20, then a fresh operation
        issue(1'b1, 32'h8765_4321, 32'h0000_0013, 0);
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check_int("midrst_ready", int'(ready_o), 0);
        check64("midrst_result", result_o, 64'd0);
        check_int("midrst_state", int'(state_o), 0);
        rst = 1'b0;
        run(1'b0, 32'd1000, 32'd33, ref_div(1'b0, 32'd1000, 32'd33));

        // Randomized operations
        for (int i = 0; i < 20; i++) begin
            r_sgn = 1'($urandom_range(0, 1));
            r_a   = $urandom;
            case ($urandom_range(0, 4))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = -32'($urandom_range(1, 15));
                default: r_b = $urandom;
            endcase
            run(r_sgn, r_a, r_b, ref_div(r_sgn, r_a, r_b));
        end

        repeat (2) @(negedge clk);
        check_int("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
Multi-cycle iterative 32-bit divider for the EX stage. It serves DIV/DIVU and pairs with the multiplier as the HI/LO producer.
- Restoring shift-subtract: one quotient bit per cycle.
- Same start/annul/ready handshake as the multiplier.
- Result packs remainder (HI) in [63:32] and quotient (LO) in [31:0].

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH; only 32 is supported by the defines.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  in  32  dividend; must stay stable while start_i=1
opdata2_i  in  32  divisor; must stay stable while start_i=1
start_i  in  1  DivStart(1) = request/hold, DivStop(0) = release
annul_i  in  1  1 = cancel in-flight operation (pipeline flush)
result_o  out  64  {remainder, quotient}
ready_o  out  1  DivResultReady(1) when result_o valid

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). rst=1 at an edge: state<=DivFree, result_o<=0, ready_o<=0, regardless of the current state, mid-operation included.
- States (2-bit): DivFree, DivByZero, DivOn, DivEnd.
- DivFree:
  - start_i=1 and annul_i=0, divisor==0: go to DivByZero.
  - start_i=1 and annul_i=0, divisor!=0: go to DivOn; cnt<=0; latch magnitudes. Signed mode negates a negative operand (two's complement). Partial remainder <=0; quotient shift reg <= |dividend|.
  - Otherwise: ready_o<=0, result_o<=0.
- DivByZero: internal result<=0; go to DivEnd. annul ignored.
- DivOn, annul_i=1: go to DivFree. ready_o stays 0 and nothing is written.
- DivOn, annul_i=0, cnt!=32: one iteration per cycle, cnt<=cnt+1.
  - Compute trial = {rem[31:0], quo[31]} - |divisor|, 33-bit.
  - No borrow: rem<=trial[31:0], quo<={quo[30:0],1}.
  - Borrow: rem<={rem[30:0],quo[31]}, quo<={quo[30:0],0}.
- DivOn, annul_i=0, cnt==32:
  - Signed and dividend[31]^divisor[31]: negate quotient.
  - Signed and dividend[31]: negate remainder (remainder takes the dividend's sign).
  - Go to DivEnd; cnt<=0.
- DivEnd: result_o<={rem,quo}; ready_o<=1.
  - If start_i=0 in the same cycle: go to DivFree, with ready_o<=0 and result_o<=0 taking priority.
  - While start_i stays 1: ready_o and result_o are held.
  - annul ignored; the controller must deassert start_i.
- Latency, start sampled at edge N:
  - Normal: DivOn at N, 32 iterations at N+1..N+32, sign fix at N+33, ready_o=1 after N+34.
  - Divisor zero: ready_o=1 after N+2.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. Wraps, no trap.
- Dividend 0 with divisor nonzero: normal 34-cycle path, result 0.

Decomposition:
- Add to defines.vh: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11, DivResultReady 1'b1, DivResultNotReady 1'b0, DivStart 1'b1, DivStop 1'b0.
- Reuse ZeroWord.
- One natural sub-module: div_step. It is combinational: takes rem, quo and divisor, and returns next rem and quo from the 33-bit trial subtract. div_iter registers its outputs.

Test Plan:
- Unsigned 100/7, start held: ready_o rises 34 cycles after start; result_o=64'h00000002_0000000E. Drop start: next edge ready_o=0, result_o=0.
- Signed -7/2 (0xFFFFFFF9, 0x00000002): result_o=64'hFFFFFFFF_FFFFFFFD. Signed 7/-2: 64'h00000001_FFFFFFFD.
- Divide by zero (signed 1234/0): ready_o=1 two cycles after start; result_o=0. Unsigned 0xFFFFFFFF/1: 64'h00000000_FFFFFFFF. Same operands signed (-1/1): 64'h00000000_FFFFFFFF.
- Signed 0x80000000/0xFFFFFFFF: result_o=64'h00000000_80000000, no hang.
- annul_i=1 on the 10th DivOn cycle: back to DivFree, ready_o never rises. Immediate new start, unsigned 9/3: 64'h00000000_00000003 after 34 cycles.
- rst=1 at iteration 20: next edge ready_o=0, result_o=0, state Free. A fresh start then completes normally.
